// File: rtl/fwd_source_pipe.sv
// fwd_source_pipe: EX/MEM and MEM/WB pipeline registers that feed the operand
// forwarding network. The block also detects load-use hazards, raises a
// one-cycle stall toward IF/ID, and keeps a saturating count of stall cycles.
module fwd_source_pipe #(
   parameter int DW = 8,
   parameter int RW = 5,
   parameter int CW = 16
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          ex_valid,
   input  logic [RW-1:0] ex_rd,
   input  logic          ex_regwrite,
   input  logic          ex_memread,
   input  logic [DW-1:0] ex_alu_result,
   input  logic          ex_flush,
   input  logic [RW-1:0] id_rs1,
   input  logic [RW-1:0] id_rs2,
   input  logic [DW-1:0] mem_rdata,
   output logic [RW-1:0] mem_rd,
   output logic          mem_regwrite,
   output logic          mem_memread,
   output logic [DW-1:0] alu_mem,
   output logic [RW-1:0] wb_rd,
   output logic          wb_regwrite,
   output logic [DW-1:0] wb_data,
   output logic          stall,
   output logic [CW-1:0] stall_cnt
);

   localparam logic [CW-1:0] CNT_MAX = '1;
   localparam logic [CW-1:0] CNT_ONE = CW'(1);

   // EX/MEM stage
   logic [RW-1:0] mem_rd_q,       mem_rd_d;
   logic          mem_regwrite_q, mem_regwrite_d;
   logic          mem_memread_q,  mem_memread_d;
   logic [DW-1:0] alu_mem_q,      alu_mem_d;
   // MEM/WB stage
   logic [RW-1:0] wb_rd_q,        wb_rd_d;
   logic          wb_regwrite_q,  wb_regwrite_d;
   logic [DW-1:0] wb_data_q,      wb_data_d;
   // Stall statistics
   logic [CW-1:0] stall_cnt_q,    stall_cnt_d;

   logic kill;
   logic ex_rd_nz;

   // A bubble or a flushed instruction enters MEM as an all-zero slot.
   assign kill     = !ex_valid || ex_flush;
   assign ex_rd_nz = (ex_rd != '0);

   // Load-use hazard: the loaded value only exists at WB, so the dependent
   // instruction in ID must wait one cycle. A flushed load creates no hazard.
   assign stall = ex_valid && !ex_flush && ex_memread && ex_rd_nz &&
                  ((ex_rd == id_rs1) || (ex_rd == id_rs2));

   // Next-state for both pipeline stages and the saturating stall counter.
   always_comb begin
      // NOTE: every _d gets a value on every path, so no latch can be inferred.
      mem_rd_d       = kill ? '0 : ex_rd;
      alu_mem_d      = kill ? '0 : ex_alu_result;
      mem_regwrite_d = !kill && ex_regwrite && ex_rd_nz;  // x0 is never written
      mem_memread_d  = !kill && ex_memread;

      wb_rd_d        = mem_rd_q;
      wb_regwrite_d  = mem_regwrite_q;
      // Load data appears here first; it is never placed on alu_mem.
      wb_data_d      = mem_memread_q ? mem_rdata : alu_mem_q;

      stall_cnt_d    = stall_cnt_q;
      if (stall && (stall_cnt_q != CNT_MAX)) begin
         stall_cnt_d = stall_cnt_q + CNT_ONE;
      end
   end

   // State update; reset clears both stages, discarding in-flight instructions.
   always_ff @(posedge clk) begin
      // NOTE: non-blocking assignments so every register samples pre-edge values.
      if (rst) begin
         mem_rd_q       <= '0;
         mem_regwrite_q <= 1'b0;
         mem_memread_q  <= 1'b0;
         alu_mem_q      <= '0;
         wb_rd_q        <= '0;
         wb_regwrite_q  <= 1'b0;
         wb_data_q      <= '0;
         stall_cnt_q    <= '0;
      end else begin
         mem_rd_q       <= mem_rd_d;
         mem_regwrite_q <= mem_regwrite_d;
         mem_memread_q  <= mem_memread_d;
         alu_mem_q      <= alu_mem_d;
         wb_rd_q        <= wb_rd_d;
         wb_regwrite_q  <= wb_regwrite_d;
         wb_data_q      <= wb_data_d;
         stall_cnt_q    <= stall_cnt_d;
      end
   end

   assign mem_rd       = mem_rd_q;
   assign mem_regwrite = mem_regwrite_q;
   assign mem_memread  = mem_memread_q;
   assign alu_mem      = alu_mem_q;
   assign wb_rd        = wb_rd_q;
   assign wb_regwrite  = wb_regwrite_q;
   assign wb_data      = wb_data_q;
   assign stall_cnt    = stall_cnt_q;

endmodule

// File: tb/tb_fwd_source_pipe.sv
// Scoreboard bench for fwd_source_pipe. The reference model tracks the
// instructions issued one and two cycles ago as plain records; a second
// instance with CW=2 exercises counter saturation on the same stimulus.
module tb_fwd_source_pipe;

   logic       clk;
   logic       rst;
   logic       ex_valid;
   logic [4:0] ex_rd;
   logic       ex_regwrite;
   logic       ex_memread;
   logic [7:0] ex_alu_result;
   logic       ex_flush;
   logic [4:0] id_rs1;
   logic [4:0] id_rs2;
   logic [7:0] mem_rdata;

   logic [4:0]  mem_rd;
   logic        mem_regwrite;
   logic        mem_memread;
   logic [7:0]  alu_mem;
   logic [4:0]  wb_rd;
   logic        wb_regwrite;
   logic [7:0]  wb_data;
   logic        stall;
   logic [15:0] stall_cnt;

   logic [4:0]  s_mem_rd;
   logic        s_mem_regwrite;
   logic        s_mem_memread;
   logic [7:0]  s_alu_mem;
   logic [4:0]  s_wb_rd;
   logic        s_wb_regwrite;
   logic [7:0]  s_wb_data;
   logic        s_stall;
   logic [1:0]  s_stall_cnt;

   fwd_source_pipe #(.DW(8), .RW(5), .CW(16)) dut (
      .clk(clk), .rst(rst), .ex_valid(ex_valid), .ex_rd(ex_rd),
      .ex_regwrite(ex_regwrite), .ex_memread(ex_memread),
      .ex_alu_result(ex_alu_result), .ex_flush(ex_flush),
      .id_rs1(id_rs1), .id_rs2(id_rs2), .mem_rdata(mem_rdata),
      .mem_rd(mem_rd), .mem_regwrite(mem_regwrite), .mem_memread(mem_memread),
      .alu_mem(alu_mem), .wb_rd(wb_rd), .wb_regwrite(wb_regwrite),
      .wb_data(wb_data), .stall(stall), .stall_cnt(stall_cnt)
   );

   fwd_source_pipe #(.DW(8), .RW(5), .CW(2)) dut_sat (
      .clk(clk), .rst(rst), .ex_valid(ex_valid), .ex_rd(ex_rd),
      .ex_regwrite(ex_regwrite), .ex_memread(ex_memread),
      .ex_alu_result(ex_alu_result), .ex_flush(ex_flush),
      .id_rs1(id_rs1), .id_rs2(id_rs2), .mem_rdata(mem_rdata),
      .mem_rd(s_mem_rd), .mem_regwrite(s_mem_regwrite), .mem_memread(s_mem_memread),
      .alu_mem(s_alu_mem), .wb_rd(s_wb_rd), .wb_regwrite(s_wb_regwrite),
      .wb_data(s_wb_data), .stall(s_stall), .stall_cnt(s_stall_cnt)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // One issued instruction as seen by the rest of the pipeline.
   typedef struct {
      bit         live;     // neither bubble nor flushed
      logic [4:0] rd;
      bit         rw;
      bit         ld;
      logic [7:0] res;
      logic [7:0] ld_data;  // memory data seen while it sat in MEM
   } slot_t;

   typedef struct {
      logic [4:0]  mem_rd;
      bit          mem_rw;
      bit          mem_mr;
      logic [7:0]  alu;
      logic [4:0]  wb_rd;
      bit          wb_rw;
      logic [7:0]  wb_data;
      bit          stall;
      logic [15:0] cnt;
      logic [1:0]  cnt2;
   } exp_t;

   exp_t  sb[$];
   slot_t s_mem, s_wb;
   slot_t bubble;
   int    total_stalls;
   bit    last_stall;
   int    n_checks;
   int    n_errors;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic int sat(input int t, input int m);
      return (t > m) ? m : t;
   endfunction

   // Drive one cycle of inputs, queue what the monitor must see, advance the model.
   task automatic cycle(input bit r, input bit v, input logic [4:0] rd, input bit rw,
                        input bit mr, input logic [7:0] res, input bit fl,
                        input logic [4:0] rs1, input logic [4:0] rs2,
                        input logic [7:0] rdata);
      exp_t e;
      rst = r; ex_valid = v; ex_rd = rd; ex_regwrite = rw; ex_memread = mr;
      ex_alu_result = res; ex_flush = fl; id_rs1 = rs1; id_rs2 = rs2;
      mem_rdata = rdata;

      e.stall   = v && !fl && mr && (rd != 0) && (rd == rs1 || rd == rs2);
      e.mem_rd  = s_mem.live ? s_mem.rd : 5'd0;
      e.mem_rw  = s_mem.live && s_mem.rw && (s_mem.rd != 0);
      e.mem_mr  = s_mem.live && s_mem.ld;
      e.alu     = s_mem.live ? s_mem.res : 8'd0;
      e.wb_rd   = s_wb.live ? s_wb.rd : 5'd0;
      e.wb_rw   = s_wb.live && s_wb.rw && (s_wb.rd != 0);
      e.wb_data = !s_wb.live ? 8'd0 : (s_wb.ld ? s_wb.ld_data : s_wb.res);
      e.cnt     = 16'(sat(total_stalls, 65535));
      e.cnt2    = 2'(sat(total_stalls, 3));
      sb.push_back(e);
      last_stall = e.stall;

      if (r) begin
         s_mem = bubble;
         s_wb  = bubble;
         total_stalls = 0;
      end else begin
         s_wb         = s_mem;
         s_wb.ld_data = rdata;
         s_mem        = '{live: v && !fl, rd: rd, rw: rw, ld: mr, res: res, ld_data: 8'd0};
         if (e.stall) total_stalls++;
      end
      @(posedge clk);
      #1;
   endtask

   // Monitor: every cycle the DUT presents a full output vector; compare it.
   initial begin
      exp_t e;
      forever begin
         @(negedge clk);
         if (sb.size() > 0) begin
            e = sb.pop_front();
            check("mem_rd",       32'(mem_rd),       32'(e.mem_rd));
            check("mem_regwrite", 32'(mem_regwrite), 32'(e.mem_rw));
            check("mem_memread",  32'(mem_memread),  32'(e.mem_mr));
            check("alu_mem",      32'(alu_mem),      32'(e.alu));
            check("wb_rd",        32'(wb_rd),        32'(e.wb_rd));
            check("wb_regwrite",  32'(wb_regwrite),  32'(e.wb_rw));
            check("wb_data",      32'(wb_data),      32'(e.wb_data));
            check("stall",        32'(stall),        32'(e.stall));
            check("stall_cnt",    32'(stall_cnt),    32'(e.cnt));
            check("stall_cnt_w2", 32'(s_stall_cnt),  32'(e.cnt2));
         end
      end
   end

   initial begin
      n_checks = 0;
      n_errors = 0;
      total_stalls = 0;
      last_stall = 1'b0;
      bubble = '{live: 1'b0, rd: 5'd0, rw: 1'b0, ld: 1'b0, res: 8'd0, ld_data: 8'd0};
      rst = 1'b1; ex_valid = 1'b0; ex_rd = '0; ex_regwrite = 1'b0; ex_memread = 1'b0;
      ex_alu_result = '0; ex_flush = 1'b0; id_rs1 = '0; id_rs2 = '0; mem_rdata = '0;
      @(posedge clk);
      #1;
      s_mem = bubble;
      s_wb  = bubble;

      // T1 ALU chain: result 20 to r1
      cycle(0, 1, 1, 1, 0, 20, 0, 9, 9, 0);
      cycle(0, 0, 0, 0, 0, 0,  0, 9, 9, 0);
      cycle(0, 0, 0, 0, 0, 0,  0, 9, 9, 0);
      // T2 load from address 8 returning 15
      cycle(0, 1, 2, 1, 1, 8,  0, 9, 9, 0);
      cycle(0, 0, 0, 0, 0, 0,  0, 9, 9, 15);
      cycle(0, 0, 0, 0, 0, 0,  0, 9, 9, 0);
      // T3 load-use on rs2, then bubble; then no-match case
      cycle(0, 1, 3, 1, 1, 8,  0, 9, 3, 0);
      cycle(0, 0, 0, 0, 0, 0,  0, 9, 3, 7);
      cycle(0, 1, 3, 1, 1, 8,  0, 4, 4, 0);
      cycle(0, 0, 0, 0, 0, 0,  0, 4, 4, 9);
      // T4 write to x0, flushed ALU op, flushed load with a match
      cycle(0, 1, 0, 1, 0, 33, 0, 0, 0, 0);
      cycle(0, 1, 5, 1, 0, 44, 1, 9, 9, 0);
      cycle(0, 1, 6, 1, 1, 55, 1, 6, 6, 0);
      cycle(0, 0, 0, 0, 0, 0,  0, 9, 9, 0);
      cycle(0, 0, 0, 0, 0, 0,  0, 9, 9, 0);
      // T5 reset with live data in both stages, then five load-use stalls
      cycle(0, 1, 7, 1, 0, 66, 0, 9, 9, 0);
      cycle(0, 1, 8, 1, 1, 77, 0, 9, 9, 0);
      cycle(1, 1, 9, 1, 0, 88, 0, 9, 9, 42);
      cycle(0, 0, 0, 0, 0, 0,  0, 9, 9, 0);
      for (int k = 0; k < 5; k++) begin
         cycle(0, 1, 10, 1, 1, 8'(k), 0, 10, 1, 0);
         cycle(0, 0, 0,  0, 0, 0,     0, 10, 1, 8'(k + 100));
      end
      cycle(0, 0, 0, 0, 0, 0, 0, 9, 9, 0);

      // Randomised traffic; a stall forces a bubble into EX on the next cycle.
      for (int n = 0; n < 400; n++) begin
         bit v;
         v = last_stall ? 1'b0 : ($urandom_range(3) != 0);
         cycle(($urandom_range(63) == 0), v, 5'($urandom_range(7)),
               1'($urandom), 1'($urandom), 8'($urandom),
               ($urandom_range(7) == 0), 5'($urandom_range(7)),
               5'($urandom_range(7)), 8'($urandom));
      end

      @(negedge clk);
      #1;
      check("scoreboard_drained", 32'(sb.size()), 32'd0);
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
